// File: rtl/fract_div_seq.sv
// Iterative radix-2 restoring fraction divider: one quotient bit per clock,
// start/done handshake, sticky remainder flag and divide-by-zero shortcut.
module fract_div_seq #(
  parameter int FRAC_W = 24,
  parameter int QUO_W  = 50,
  parameter int SIDE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRAC_W-1:0] fracta,
  input  logic [FRAC_W-1:0] fractb,
  input  logic [SIDE_W-1:0] side_in,
  output logic              busy,
  output logic              done,
  output logic [QUO_W-1:0]  quo,
  output logic              rem_nz,
  output logic              div_zero,
  output logic [SIDE_W-1:0] side_out
);

  // Handshake: start is sampled only while idle (busy low); done is a
  // single-cycle pulse during which quo/rem_nz/div_zero/side_out are valid,
  // and those outputs then hold until the next operation completes.

  localparam int CNT_W = $clog2(QUO_W);

  typedef enum logic [1:0] {IDLE, DIV, ZERO, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [FRAC_W:0]     rem_q;
  logic [FRAC_W-1:0]   dvsr;
  logic [QUO_W-1:0]    dvd;
  logic [QUO_W-1:0]    quo_q;
  logic [SIDE_W-1:0]   side_q;

  logic [FRAC_W:0]     r_shift;
  logic [FRAC_W:0]     r_next;
  logic                q_bit;
  logic [QUO_W-1:0]    q_next;

  // One restoring step: R is always below the divisor, so FRAC_W+1 bits suffice.
  always_comb begin
    r_shift = {rem_q[FRAC_W-1:0], dvd[QUO_W-1]};
    q_bit   = (r_shift >= {1'b0, dvsr});
    r_next  = q_bit ? (r_shift - {1'b0, dvsr}) : r_shift;
    q_next  = {quo_q[QUO_W-2:0], q_bit};
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    unique case (state)
      IDLE: if (start) state_nxt = (fractb == '0) ? ZERO : DIV;
      DIV:  if (cnt == '0) state_nxt = DONE;
      ZERO: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      dvsr     <= '0;
      dvd      <= '0;
      quo_q    <= '0;
      side_q   <= '0;
      quo      <= '0;
      rem_nz   <= 1'b0;
      div_zero <= 1'b0;
      side_out <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvsr   <= fractb;
            dvd    <= {fracta, {(QUO_W-FRAC_W){1'b0}}};
            side_q <= side_in;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt    <= CNT_W'(QUO_W-1);
          end
        end
        DIV: begin
          rem_q <= r_next;
          dvd   <= dvd << 1;
          quo_q <= q_next;
          cnt   <= cnt - CNT_W'(1);
          // Publish only the finished quotient, on the step that enters DONE.
          if (cnt == '0) begin
            quo      <= q_next;
            rem_nz   <= |r_next;
            div_zero <= 1'b0;
            side_out <= side_q;
          end
        end
        ZERO: begin
          quo      <= '1;
          rem_nz   <= 1'b0;
          div_zero <= 1'b1;
          side_out <= side_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fract_div_seq.sv
// Bench for fract_div_seq: directed cases, handshake/latency checks and
// randomized operands against an arithmetic reference quotient.
module tb_fract_div_seq;

  localparam int FRAC_W = 24;
  localparam int QUO_W  = 50;
  localparam int SIDE_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [FRAC_W-1:0] fracta;
  logic [FRAC_W-1:0] fractb;
  logic [SIDE_W-1:0] side_in;
  logic              busy;
  logic              done;
  logic [QUO_W-1:0]  quo;
  logic              rem_nz;
  logic              div_zero;
  logic [SIDE_W-1:0] side_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  fract_div_seq #(.FRAC_W(FRAC_W), .QUO_W(QUO_W), .SIDE_W(SIDE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .fracta   (fracta),
    .fractb   (fractb),
    .side_in  (side_in),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem_nz   (rem_nz),
    .div_zero (div_zero),
    .side_out (side_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: quotient of the fraction scaled by 2^(QUO_W-FRAC_W).
  function automatic void model(input logic [FRAC_W-1:0] a, input logic [FRAC_W-1:0] b,
                                output logic [QUO_W-1:0] q, output logic rnz, output logic dz);
    longint unsigned num;
    if (b == 0) begin
      q = '1; rnz = 1'b0; dz = 1'b1;
    end else begin
      num = longint'(a) * (longint'(1) << (QUO_W - FRAC_W));
      q   = QUO_W'(num / longint'(b));
      rnz = (num % longint'(b)) != 0;
      dz  = 1'b0;
    end
  endfunction

  // Caller is at a negedge. Issues one op, waits for done, checks everything.
  task automatic do_op(input string tag, input logic [FRAC_W-1:0] a, input logic [FRAC_W-1:0] b,
                       input logic [SIDE_W-1:0] side, input bit spam, output int acc);
    logic [QUO_W-1:0] eq;
    logic             ernz, edz;
    int               lat;
    bit               busy_ok;
    model(a, b, eq, ernz, edz);
    fracta = a; fractb = b; side_in = side; start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    fracta = FRAC_W'($urandom); fractb = FRAC_W'($urandom); side_in = SIDE_W'($urandom);
    lat = 0; busy_ok = 1'b1;
    @(negedge clk);
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (spam) begin
        start = 1'b1;
        fracta = FRAC_W'($urandom); fractb = FRAC_W'($urandom); side_in = SIDE_W'($urandom);
      end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'(QUO_W));
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    check({tag, "_quo"}, 64'(quo), 64'(eq));
    check({tag, "_rem_nz"}, 64'(rem_nz), 64'(ernz));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(edz));
    check({tag, "_side"}, 64'(side_out), 64'(side));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_quo_hold"}, 64'(quo), 64'(eq));
  endtask

  initial begin
    int acc0, acc1;
    bit saw_done;
    logic [FRAC_W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; fracta = '0; fractb = '0; side_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quo", 64'(quo), 64'd0);
    check("rst_rem_nz", 64'(rem_nz), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_side", 64'(side_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed quotients.
    do_op("one", 24'h800000, 24'h800000, 16'h1234, 1'b0, acc0);
    check("one_const", 64'(quo), 64'h0000004000000);
    do_op("third", 24'h800000, 24'hC00000, 16'hA5C3, 1'b0, acc0);
    check("third_const", 64'(quo), 64'h0000002AAAAAA);
    check("third_rnz", 64'(rem_nz), 64'd1);
    do_op("onehalf", 24'hC00000, 24'h800000, 16'h0F0F, 1'b0, acc0);
    check("onehalf_const", 64'(quo), 64'h0000006000000);
    do_op("dzero", 24'h9ABCDE, 24'h000000, 16'h5555, 1'b0, acc0);
    check("dzero_const", 64'(quo), {14'd0, {QUO_W{1'b1}}});
    do_op("clear_dz", 24'hFFFFFF, 24'h000001, 16'hBEEF, 1'b0, acc0);
    check("clear_dz_flag", 64'(div_zero), 64'd0);
    do_op("a_zero", 24'h000000, 24'h812345, 16'h0001, 1'b0, acc0);

    // Starts while busy must be ignored; next start right after done is taken.
    do_op("spam", 24'hA00000, 24'hE00000, 16'h7777, 1'b1, acc0);
    do_op("b2b", 24'hFFFFFF, 24'h800001, 16'h8888, 1'b0, acc1);
    check("b2b_interval", 64'(acc1 - acc0), 64'(QUO_W + 2));

    // Reset 20 cycles into a divide aborts it silently.
    fracta = 24'hD00000; fractb = 24'h900000; side_in = 16'hCAFE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_quo", 64'(quo), 64'd0);
    check("abort_side", 64'(side_out), 64'd0);
    check("abort_rem_nz", 64'(rem_nz), 64'd0);
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    do_op("post_abort", 24'hD00000, 24'h900000, 16'hCAFE, 1'b0, acc0);

    // Reset and start together: start is dropped.
    rst = 1'b1; start = 1'b1; fracta = 24'h800000; fractb = 24'h800000;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_start_busy2", 64'(busy), 64'd0);

    // Randomized operands, biased toward denormal, zero and tiny values.
    for (int i = 0; i < 150; i++) begin
      ra = FRAC_W'($urandom);
      rb = FRAC_W'($urandom);
      case ($urandom_range(0, 9))
        0: ra = '0;
        1: rb = FRAC_W'($urandom_range(0, 3));
        2: rb = rb >> $urandom_range(1, 23);
        3: ra = ra >> $urandom_range(1, 23);
        default: begin
          ra[FRAC_W-1] = 1'b1;
          rb[FRAC_W-1] = 1'b1;
        end
      endcase
      do_op("rand", ra, rb, SIDE_W'($urandom), bit'($urandom_range(0, 1)), acc0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
